// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the add/sub pipeline:
//   mode_e         - operation select (ADD, SUB, ACC, SAT)
//   LAT_MIN/LAT_MAX - legal range of the pipeline latency parameter
//   clamp_lat()    - folds an out-of-range latency into the legal range
// Optional feature macro used by the importing RTL: ADDSUB_PIPE_SAT_EN
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_SAT = 2'b11
  } mode_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Keeps the stage count inside the range the pipeline is built for.
  function automatic int clamp_lat(input int lat);
    int res;
    if (lat < LAT_MIN) begin
      res = LAT_MIN;
    end else if (lat > LAT_MAX) begin
      res = LAT_MAX;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// -----------------------------------------------------------------------------
// addsub_stage
// One stallable register stage of the add/sub pipeline.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   stall            - global stall, holds the stage contents when high
//   d_valid/d_y/d_ovf - stage input (valid flag, result, overflow flag)
//   q_valid/q_y/q_ovf - registered stage output
// -----------------------------------------------------------------------------
module addsub_stage #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         d_valid,
  input  logic [W-1:0] d_y,
  input  logic         d_ovf,
  output logic         q_valid,
  output logic [W-1:0] q_y,
  output logic         q_ovf
);

  // Stage register: cleared by reset, frozen while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_y     <= '0;
      q_ovf   <= 1'b0;
    end else if (!stall) begin
      q_valid <= d_valid;
      q_y     <= d_y;
      q_ovf   <= d_ovf;
    end else begin
      q_valid <= q_valid;
      q_y     <= q_y;
      q_ovf   <= q_ovf;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Pipelined unsigned add / subtract / accumulate / saturating-add unit with a
// valid/ready handshake on both sides and a global stall.
// Parameters: W (operand width), LAT (acceptance-to-result latency in cycles).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake
//   mode                - 00 ADD, 01 SUB, 10 ACC, 11 SAT
//   a, b                - unsigned operands
//   acc_clr             - synchronous accumulator clear (applied before an ACC add)
//   out_valid, out_ready - result handshake
//   y, ovf              - result and carry/borrow/saturation flag
// Optional feature: define ADDSUB_PIPE_SAT_EN to enable saturation in mode 11;
// without it mode 11 is a plain wrapping ADD.
// -----------------------------------------------------------------------------
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int W   = 12,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam int STAGES = clamp_lat(LAT);

  logic                      stall_s;
  logic                      accept_s;
  logic [W-1:0]              acc_r;
  logic [W-1:0]              acc_base_s;
  logic [W:0]                sum_s;
  logic [W:0]                diff_s;
  logic [W:0]                acc_sum_s;
  logic [W-1:0]              res_y_s;
  logic                      res_ovf_s;
  logic [STAGES:0]           stg_valid_s;
  logic [STAGES:0][W-1:0]    stg_y_s;
  logic [STAGES:0]           stg_ovf_s;

  // A held result at the output freezes the whole pipe and blocks new input.
  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;
  assign accept_s = in_valid && in_ready;

  // Result arithmetic, computed ahead of the first stage.
  always_comb begin
    // Clear takes effect before the add so acc_clr with ACC yields acc = a.
    acc_base_s = acc_clr ? '0 : acc_r;
    sum_s      = {1'b0, a} + {1'b0, b};
    // Bit W of the extended difference is the borrow (a < b).
    diff_s     = {1'b0, a} - {1'b0, b};
    acc_sum_s  = {1'b0, acc_base_s} + {1'b0, a};
    res_y_s    = sum_s[W-1:0];
    res_ovf_s  = sum_s[W];
    case (mode_e'(mode))
      MODE_ADD: begin
        res_y_s   = sum_s[W-1:0];
        res_ovf_s = sum_s[W];
      end
      MODE_SUB: begin
        res_y_s   = diff_s[W-1:0];
        res_ovf_s = diff_s[W];
      end
      MODE_ACC: begin
        res_y_s   = acc_sum_s[W-1:0];
        res_ovf_s = acc_sum_s[W];
      end
      MODE_SAT: begin
`ifdef ADDSUB_PIPE_SAT_EN
        if (sum_s[W]) begin
          res_y_s   = '1;
          res_ovf_s = 1'b1;
        end else begin
          res_y_s   = sum_s[W-1:0];
          res_ovf_s = 1'b0;
        end
`else
        res_y_s   = sum_s[W-1:0];
        res_ovf_s = sum_s[W];
`endif
      end
      default: begin
        res_y_s   = sum_s[W-1:0];
        res_ovf_s = sum_s[W];
      end
    endcase
  end

  // Accumulator: moves only on an accepted ACC or on a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (accept_s && (mode_e'(mode) == MODE_ACC)) begin
      acc_r <= acc_sum_s[W-1:0];
    end else if (acc_clr) begin
      acc_r <= '0;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign stg_valid_s[0] = accept_s;
  assign stg_y_s[0]     = res_y_s;
  assign stg_ovf_s[0]   = res_ovf_s;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    addsub_stage #(.W(W)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall   (stall_s),
      .d_valid (stg_valid_s[i]),
      .d_y     (stg_y_s[i]),
      .d_ovf   (stg_ovf_s[i]),
      .q_valid (stg_valid_s[i+1]),
      .q_y     (stg_y_s[i+1]),
      .q_ovf   (stg_ovf_s[i+1])
    );
  end

  assign out_valid = stg_valid_s[STAGES];
  assign y         = stg_y_s[STAGES];
  assign ovf       = stg_ovf_s[STAGES];

endmodule

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe
// Self-checking bench for addsub_pipe (W=12, LAT=2). A transaction-level model
// (queue of expected results, each becoming visible after LAT unstalled
// cycles) is compared with the DUT outputs every cycle; directed vectors with
// hand-computed literals pin the model. SAT expectations follow
// ADDSUB_PIPE_SAT_EN.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;

  localparam int W    = 12;
  localparam int LAT  = 2;
  localparam int MODV = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  y;
  logic          ovf;

  addsub_pipe #(.W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int ovf; int tag; } exp_t;
  typedef struct { int y; int ovf; int cyc; } obs_t;

  exp_t exp_q[$];
  obs_t log_q[$];
  int   macc = 0;
  int   adv = 0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: results become visible LAT unstalled edges after acceptance.
  bit   m_vis, m_stall;
  int   m_s, m_a, m_b, m_base;
  exp_t m_e;
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      m_vis   = (exp_q.size() > 0) && (exp_q[0].tag <= adv);
      m_stall = m_vis && !out_ready;
      m_base  = acc_clr ? 0 : macc;
      if (acc_clr) macc = 0;
      if (!m_stall) begin
        if (m_vis) void'(exp_q.pop_front());
        adv++;
        if (in_valid) begin
          m_a = int'(a);
          m_b = int'(b);
          case (mode)
            2'b01: begin
              m_e.y   = (m_a - m_b + MODV) % MODV;
              m_e.ovf = (m_a < m_b) ? 1 : 0;
            end
            2'b10: begin
              m_s     = m_base + m_a;
              m_e.y   = m_s % MODV;
              m_e.ovf = (m_s >= MODV) ? 1 : 0;
              macc    = m_e.y;
            end
            2'b11: begin
              m_s = m_a + m_b;
`ifdef ADDSUB_PIPE_SAT_EN
              m_e.y = (m_s >= MODV) ? MODV - 1 : m_s;
`else
              m_e.y = m_s % MODV;
`endif
              m_e.ovf = (m_s >= MODV) ? 1 : 0;
            end
            default: begin
              m_s     = m_a + m_b;
              m_e.y   = m_s % MODV;
              m_e.ovf = (m_s >= MODV) ? 1 : 0;
            end
          endcase
          m_e.tag = adv + LAT - 1;
          exp_q.push_back(m_e);
        end
      end
    end
  end

  // Compare process: DUT outputs against the model, every cycle out of reset.
  bit c_vis;
  obs_t c_o;
  always @(negedge clk) begin
    if (rst_n) begin
      c_vis = (exp_q.size() > 0) && (exp_q[0].tag <= adv);
      chk("out_valid", int'(out_valid), int'(c_vis));
      chk("in_ready", int'(in_ready), int'(!(c_vis && !out_ready)));
      if (c_vis) begin
        chk("y", int'(y), exp_q[0].y);
        chk("ovf", int'(ovf), exp_q[0].ovf);
      end
      if (out_valid && out_ready) begin
        c_o.y   = int'(y);
        c_o.ovf = int'(ovf);
        c_o.cyc = cyc;
        log_q.push_back(c_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input int av, input int bv, input logic clr);
    int n;
    n        = 0;
    mode     = m;
    a        = av[W-1:0];
    b        = bv[W-1:0];
    acc_clr  = clr;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", n, 0);
    step();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_q.size() < n && k < 100) begin
      step();
      k++;
    end
    chk("result_count", log_q.size(), n);
  endtask

  task automatic chk_log(input string name, input int idx, input int ey, input int eovf);
    if (idx < log_q.size()) begin
      chk({name, "_y"}, log_q[idx].y, ey);
      chk({name, "_ovf"}, log_q[idx].ovf, eovf);
    end else begin
      chk({name, "_missing"}, -1, ey);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_ovf", int'(ovf), 0);
    exp_q.delete();
    macc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    step();
  endtask

  int base;
  int sat_y;

  initial begin
    do_reset();

    // ADD carry out, with exact latency
    send(2'b00, 'h7FF, 'h801, 1'b0);
    @(negedge clk);
    chk("lat1_out_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat2_out_valid", int'(out_valid), 1);
    chk("add_carry_y", int'(y), 'h000);
    chk("add_carry_ovf", int'(ovf), 1);
    step();

    // SUB both directions, plain ADD, SAT unclamped and clamped
    base = log_q.size();
    send(2'b01, 5, 9, 1'b0);
    send(2'b01, 9, 5, 1'b0);
    send(2'b00, 'h123, 'h456, 1'b0);
    send(2'b11, 'h100, 'h200, 1'b0);
    send(2'b11, 'hF00, 'h200, 1'b0);
    wait_log(base + 5);
    chk_log("sub_borrow", base, 'hFFC, 1);
    chk_log("sub_plain", base + 1, 4, 0);
    chk_log("add_plain", base + 2, 'h579, 0);
    chk_log("sat_small", base + 3, 'h300, 0);
`ifdef ADDSUB_PIPE_SAT_EN
    sat_y = 'hFFF;
`else
    sat_y = 'h100;
`endif
    chk_log("sat_big", base + 4, sat_y, 1);

    // Accumulator: clear, back-to-back adds, clear+add, wrap
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    base = log_q.size();
    send(2'b10, 10, 99, 1'b0);
    send(2'b10, 20, 0, 1'b0);
    send(2'b10, 30, 0, 1'b0);
    send(2'b10, 7, 0, 1'b1);
    send(2'b10, 'hFFA, 0, 1'b0);
    wait_log(base + 5);
    chk_log("acc1", base, 10, 0);
    chk_log("acc2", base + 1, 30, 0);
    chk_log("acc3", base + 2, 60, 0);
    chk_log("acc_clr_add", base + 3, 7, 0);
    chk_log("acc_wrap", base + 4, 1, 1);
    if (log_q.size() >= base + 3) begin
      chk("acc_consecutive1", log_q[base + 1].cyc - log_q[base].cyc, 1);
      chk("acc_consecutive2", log_q[base + 2].cyc - log_q[base + 1].cyc, 1);
    end
    // idle clear, then acc restarts from zero
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    base = log_q.size();
    send(2'b10, 5, 0, 1'b0);
    wait_log(base + 1);
    chk_log("acc_idle_clr", base, 5, 0);

    // Back-pressure: output held for 4 cycles, third operand waits
    step();
    base = log_q.size();
    out_ready = 1'b0;
    send(2'b00, 1, 2, 1'b0);
    send(2'b00, 3, 4, 1'b0);
    mode     = 2'b00;
    a        = 12'd5;
    b        = 12'd6;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_y_held", int'(y), 3);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_log(base + 3);
    repeat (4) step();
    chk("stall_no_dup", log_q.size(), base + 3);
    chk_log("stall_r1", base, 3, 0);
    chk_log("stall_r2", base + 1, 7, 0);
    chk_log("stall_r3", base + 2, 11, 0);

    // Reset with two transactions in flight
    base = log_q.size();
    send(2'b10, 100, 0, 1'b0);
    send(2'b00, 2, 2, 1'b0);
    do_reset();
    repeat (5) step();
    chk("rst_no_result", log_q.size(), base);
    send(2'b10, 3, 0, 1'b0);
    wait_log(base + 1);
    chk_log("rst_acc_zero", base, 3, 0);

    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
